flash_pad_arbiter: RTL and testbench

- Shares the single set of SPI flash pads (CS_N, CLK, four bidirectional data lines) between two requesters.
- Requester A is the microwatt SPI flash controller. Requester B is a host-side flash programmer driven from the management side.
- A req/gnt handshake sequences ownership. A forced idle gap with CS_N high separates owners.
- An owner that hogs the pads is preempted, but only at a transaction boundary.

---
 rtl/flash_pad_arbiter.sv | 138 +++++++++++++
 tb/tb_flash_pad_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_pad_arbiter.sv
// Two-requester arbiter for the shared SPI flash pads. It grants the pads
// through a req/gnt handshake, parks them for an idle gap between owners,
// and preempts a long-running owner only while its chip select is high.
module flash_pad_arbiter #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned MAX_HOLD   = 1024
) (
  input  logic       ext_clk,
  input  logic       ext_rst_n,
  input  logic       a_req,
  output logic       a_gnt,
  input  logic       a_cs_n,
  input  logic       a_clk,
  input  logic [3:0] a_sdat_o,
  input  logic [3:0] a_sdat_oe,
  output logic [3:0] a_sdat_i,
  input  logic       b_req,
  output logic       b_gnt,
  input  logic       b_cs_n,
  input  logic       b_clk,
  input  logic [3:0] b_sdat_o,
  input  logic [3:0] b_sdat_oe,
  output logic [3:0] b_sdat_i,
  output logic       pad_cs_n,
  output logic       pad_clk,
  output logic [3:0] pad_o,
  output logic [3:0] pad_oe,
  input  logic [3:0] pad_i,
  output logic [1:0] owner,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;

  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] HOLD_MAX = 16'(MAX_HOLD);

  state_t      state_q, state_d;
  logic [7:0]  gap_cnt_q;
  logic [15:0] hold_cnt_q;
  logic        last_b_q;     // 1: B owned last, so A wins the next tie
  logic        own_req, other_req, own_cs_n;
  logic        preempt_d;
  logic        stay_a, stay_b;

  // Next-state selection, including the transaction-boundary preemption test
  always_comb begin
    state_d   = state_q;
    preempt_d = 1'b0;
    own_req   = 1'b0;
    other_req = 1'b0;
    own_cs_n  = 1'b1;
    case (state_q)
      IDLE: begin
        if (a_req && (!b_req || last_b_q)) state_d = OWN_A;
        else if (b_req)                    state_d = OWN_B;
      end
      OWN_A, OWN_B: begin
        own_req   = (state_q == OWN_A) ? a_req  : b_req;
        other_req = (state_q == OWN_A) ? b_req  : a_req;
        own_cs_n  = (state_q == OWN_A) ? a_cs_n : b_cs_n;
        if (!own_req) begin
          state_d = GAP;
        end else if (other_req && hold_cnt_q == HOLD_MAX && own_cs_n) begin
          state_d   = GAP;
          preempt_d = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pads only carry an owner's signals on edges where that owner keeps the grant
  assign stay_a = (state_q == OWN_A) && (state_d == OWN_A);
  assign stay_b = (state_q == OWN_B) && (state_d == OWN_B);

  // State, counters, registered status outputs and registered pad drivers
  always_ff @(posedge ext_clk) begin
    if (!ext_rst_n) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      hold_cnt_q <= '0;
      last_b_q   <= 1'b1;
      preempt    <= 1'b0;
      owner      <= 2'b00;
      pad_cs_n   <= 1'b1;
      pad_clk    <= 1'b0;
      pad_o      <= '0;
      pad_oe     <= '0;
    end else begin
      state_q <= state_d;
      preempt <= preempt_d;
      case (state_d)
        IDLE:    owner <= 2'b00;
        OWN_A:   owner <= 2'b01;
        OWN_B:   owner <= 2'b10;
        default: owner <= 2'b11;
      endcase

      gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 8'd1 : '0;

      if (stay_a || stay_b) begin
        if (hold_cnt_q != HOLD_MAX) hold_cnt_q <= hold_cnt_q + 16'd1;
      end else begin
        hold_cnt_q <= '0;
      end

      if (state_q == OWN_A && state_d == GAP) last_b_q <= 1'b0;
      if (state_q == OWN_B && state_d == GAP) last_b_q <= 1'b1;

      if (stay_a) begin
        pad_cs_n <= a_cs_n;
        pad_clk  <= a_clk;
        pad_o    <= a_sdat_o;
        pad_oe   <= a_sdat_oe;
      end else if (stay_b) begin
        pad_cs_n <= b_cs_n;
        pad_clk  <= b_clk;
        pad_o    <= b_sdat_o;
        pad_oe   <= b_sdat_oe;
      end else begin
        pad_cs_n <= 1'b1;
        pad_clk  <= 1'b0;
        pad_o    <= '0;
        pad_oe   <= '0;
      end
    end
  end

  assign a_gnt    = (state_q == OWN_A);
  assign b_gnt    = (state_q == OWN_B);
  assign a_sdat_i = a_gnt ? pad_i : 4'b0000;
  assign b_sdat_i = b_gnt ? pad_i : 4'b0000;

endmodule

// File: tb/tb_flash_pad_arbiter.sv
// Bench for flash_pad_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against an ownership model.
module tb_flash_pad_arbiter;

  localparam int GAP  = 4;
  localparam int HOLD = 16;

  logic       ext_clk = 1'b0;
  logic       ext_rst_n;
  logic       a_req, a_gnt, a_cs_n, a_clk;
  logic [3:0] a_sdat_o, a_sdat_oe, a_sdat_i;
  logic       b_req, b_gnt, b_cs_n, b_clk;
  logic [3:0] b_sdat_o, b_sdat_oe, b_sdat_i;
  logic       pad_cs_n, pad_clk;
  logic [3:0] pad_o, pad_oe, pad_i;
  logic [1:0] owner;
  logic       preempt;

  int vectors = 0;
  int miscompares = 0;

  flash_pad_arbiter #(.GAP_CYCLES(GAP), .MAX_HOLD(HOLD)) dut (
    .ext_clk(ext_clk), .ext_rst_n(ext_rst_n),
    .a_req(a_req), .a_gnt(a_gnt), .a_cs_n(a_cs_n), .a_clk(a_clk),
    .a_sdat_o(a_sdat_o), .a_sdat_oe(a_sdat_oe), .a_sdat_i(a_sdat_i),
    .b_req(b_req), .b_gnt(b_gnt), .b_cs_n(b_cs_n), .b_clk(b_clk),
    .b_sdat_o(b_sdat_o), .b_sdat_oe(b_sdat_oe), .b_sdat_i(b_sdat_i),
    .pad_cs_n(pad_cs_n), .pad_clk(pad_clk), .pad_o(pad_o), .pad_oe(pad_oe),
    .pad_i(pad_i), .owner(owner), .preempt(preempt)
  );

  always #5 ext_clk = ~ext_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the pads (0 none, 1 A, 2 B, 3 gap), how long
  // they have held, gap cycles still to run, and who is preferred on a tie.
  int   m_own = 0, m_held = 0, m_gap_left = 0;
  bit   m_prefer_a = 1, m_live = 0, m_pre = 0;
  logic m_pcs = 1, m_pclk = 0;
  logic [3:0] m_po = 0, m_poe = 0;

  always @(posedge ext_clk) begin : model
    bit xr, orq, xcs;
    if (!ext_rst_n) begin
      m_own = 0; m_held = 0; m_gap_left = 0; m_prefer_a = 1; m_pre = 0;
      m_pcs = 1; m_pclk = 0; m_po = 0; m_poe = 0; m_live = 1;
    end else if (m_live) begin
      m_pre = 0; m_pcs = 1; m_pclk = 0; m_po = 0; m_poe = 0;
      if (m_own == 0) begin
        if (a_req && (!b_req || m_prefer_a)) begin m_own = 1; m_held = 0; end
        else if (b_req)                      begin m_own = 2; m_held = 0; end
      end else if (m_own == 3) begin
        m_gap_left--;
        if (m_gap_left == 0) m_own = 0;
      end else begin
        xr  = (m_own == 1) ? a_req  : b_req;
        orq = (m_own == 1) ? b_req  : a_req;
        xcs = (m_own == 1) ? a_cs_n : b_cs_n;
        if (!xr || (orq && m_held >= HOLD && xcs)) begin
          m_pre = xr;
          m_prefer_a = (m_own == 2);
          m_own = 3;
          m_gap_left = GAP;
        end else begin
          m_held++;
          if (m_own == 1) begin m_pcs = a_cs_n; m_pclk = a_clk; m_po = a_sdat_o; m_poe = a_sdat_oe; end
          else            begin m_pcs = b_cs_n; m_pclk = b_clk; m_po = b_sdat_o; m_poe = b_sdat_oe; end
        end
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge ext_clk) begin
    if (m_live) begin
      chk("a_gnt",    a_gnt,    (m_own == 1));
      chk("b_gnt",    b_gnt,    (m_own == 2));
      chk("owner",    owner,    m_own);
      chk("preempt",  preempt,  m_pre);
      chk("pad_cs_n", pad_cs_n, m_pcs);
      chk("pad_clk",  pad_clk,  m_pclk);
      chk("pad_o",    pad_o,    m_po);
      chk("pad_oe",   pad_oe,   m_poe);
      chk("a_sdat_i", a_sdat_i, (m_own == 1) ? pad_i : 4'h0);
      chk("b_sdat_i", b_sdat_i, (m_own == 2) ? pad_i : 4'h0);
      chk("gnt_excl", a_gnt & b_gnt, 1'b0);
    end
  end

  task automatic step();
    @(posedge ext_clk);
    #2;
  endtask

  int gap_seen;
  int seq[4];
  int nseq;
  int a_cnt, b_cnt;
  bit pa, pb;

  initial begin
    ext_rst_n = 0; a_req = 1; b_req = 1;
    a_cs_n = 1; a_clk = 0; a_sdat_o = 0; a_sdat_oe = 0;
    b_cs_n = 1; b_clk = 0; b_sdat_o = 0; b_sdat_oe = 0;
    pad_i = 0;

    // Reset held with both requesting
    repeat (3) step();
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_pad_cs_n", pad_cs_n, 1);
    chk("rst_pad_oe", pad_oe, 0);
    chk("rst_owner", owner, 0);
    ext_rst_n = 1;
    step();
    chk("first_tie_a_gnt", a_gnt, 1);
    chk("first_tie_owner", owner, 1);

    // Pass-through with one cycle of latency; return data is combinational
    b_req = 0;
    a_cs_n = 0; a_sdat_oe = 4'hF; a_sdat_o = 4'hA; pad_i = 4'h5;
    #1;
    chk("pt_a_sdat_i", a_sdat_i, 4'h5);
    chk("pt_b_sdat_i", b_sdat_i, 4'h0);
    step();
    chk("pt_pad_cs_n", pad_cs_n, 0);
    chk("pt_pad_oe", pad_oe, 4'hF);
    chk("pt_pad_o", pad_o, 4'hA);

    // Handover from A to B through the gap
    a_cs_n = 1; a_sdat_oe = 0; a_sdat_o = 0;
    b_cs_n = 0; b_sdat_o = 4'h3; b_sdat_oe = 4'h5;
    a_req = 0; b_req = 1;
    step();
    gap_seen = 0;
    for (int i = 0; i < 20 && !b_gnt; i++) begin
      if (owner == 2'b11) begin
        gap_seen++;
        chk("gap_pad_cs_n", pad_cs_n, 1);
      end
      step();
    end
    chk("gap_cycles", gap_seen, GAP);
    chk("handover_b_gnt", b_gnt, 1);
    chk("handover_pad_parked", pad_cs_n, 1);
    step();
    chk("handover_pad_cs_n", pad_cs_n, 0);
    chk("handover_pad_o", pad_o, 4'h3);
    b_req = 0; b_cs_n = 1; b_sdat_o = 0; b_sdat_oe = 0;
    for (int i = 0; i < 20 && owner != 2'b00; i++) step();
    chk("handover_idle", owner, 0);

    // Preemption only once A's chip select rises
    a_req = 1;
    step();
    chk("pre_a_gnt", a_gnt, 1);
    a_cs_n = 0; b_req = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("no_preempt_cs_low", preempt, 0);
      chk("keep_a_gnt", a_gnt, 1);
    end
    a_cs_n = 1;
    step();
    chk("preempt_pulse", preempt, 1);
    chk("preempt_a_gnt", a_gnt, 0);
    chk("preempt_owner", owner, 3);
    step();
    chk("preempt_one_cycle", preempt, 0);
    for (int i = 0; i < 20 && !b_gnt; i++) step();
    chk("preempt_b_gnt", b_gnt, 1);
    a_req = 0; b_req = 0;
    for (int i = 0; i < 20 && owner != 2'b00; i++) step();
    chk("preempt_idle", owner, 0);

    // Round-robin with both requesters re-requesting after 8 owned cycles
    nseq = 0; a_cnt = 0; b_cnt = 0; pa = 0; pb = 0;
    a_req = 1; b_req = 1;
    for (int i = 0; i < 200 && nseq < 4; i++) begin
      step();
      if (a_gnt && !pa) begin seq[nseq] = 1; nseq++; end
      if (b_gnt && !pb && nseq < 4) begin seq[nseq] = 2; nseq++; end
      pa = a_gnt; pb = b_gnt;
      if (a_gnt) begin a_cnt++; a_req = (a_cnt < 8); if (a_cnt >= 8) a_cnt = 0; end
      else begin a_cnt = 0; a_req = 1; end
      if (b_gnt) begin b_cnt++; b_req = (b_cnt < 8); if (b_cnt >= 8) b_cnt = 0; end
      else begin b_cnt = 0; b_req = 1; end
    end
    chk("rr_count", nseq, 4);
    chk("rr_0", seq[0], 1);
    chk("rr_1", seq[1], 2);
    chk("rr_2", seq[2], 1);
    chk("rr_3", seq[3], 2);
    a_req = 0; b_req = 0;
    for (int i = 0; i < 30 && owner != 2'b00; i++) step();
    chk("rr_idle", owner, 0);

    // Reset in the middle of a B transfer
    b_req = 1;
    for (int i = 0; i < 20 && !b_gnt; i++) step();
    chk("mid_b_gnt", b_gnt, 1);
    b_cs_n = 0;
    step();
    chk("mid_pad_cs_n", pad_cs_n, 0);
    ext_rst_n = 0;
    step();
    chk("mid_rst_b_gnt", b_gnt, 0);
    chk("mid_rst_pad_cs_n", pad_cs_n, 1);
    chk("mid_rst_owner", owner, 0);
    ext_rst_n = 1; a_req = 1; b_cs_n = 1;
    step();
    chk("mid_rst_tie_a", a_gnt, 1);

    // Randomized traffic, checked by the per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) a_req = ~a_req;
      if ($urandom_range(19) == 0) b_req = ~b_req;
      a_cs_n = ($urandom_range(9) < 6); b_cs_n = ($urandom_range(9) < 6);
      a_clk = 1'($urandom); b_clk = 1'($urandom);
      a_sdat_o = 4'($urandom); a_sdat_oe = 4'($urandom);
      b_sdat_o = 4'($urandom); b_sdat_oe = 4'($urandom);
      pad_i = 4'($urandom);
      ext_rst_n = ($urandom_range(299) != 0);
      step();
    end
    ext_rst_n = 1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
